// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state encoding,
// interrupt push codes and register address width.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    // Debug-visible state encoding; values are observed on the state port
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_MEM_WAIT  = 3'd1,
        ST_INT_PC    = 3'd2,
        ST_INT_FLAGS = 3'd3,
        ST_INT_JUMP  = 3'd4
    } state_t;

    // Interrupt stack push requests
    localparam logic [1:0] PUSH_NONE  = 2'b00;
    localparam logic [1:0] PUSH_PC    = 2'b01;
    localparam logic [1:0] PUSH_FLAGS = 2'b10;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the load sitting in Execute writes
// a register that the instruction in Decode is about to read.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic                  i_de_mem_read,
    input  logic [REG_ADDR_W-1:0] i_de_write_add,
    input  logic [REG_ADDR_W-1:0] i_fd_src1,
    input  logic [REG_ADDR_W-1:0] i_fd_src2,
    input  logic [1:0]            i_fd_src_valid,
    output logic                  o_hazard
);

    logic w_src1Hit;
    logic w_src2Hit;

    // Only sources that Decode actually uses can create a dependency
    always_comb begin
        w_src1Hit = i_fd_src_valid[0] && (i_fd_src1 == i_de_write_add);
        w_src2Hit = i_fd_src_valid[1] && (i_fd_src2 == i_de_write_add);
        o_hazard  = i_de_mem_read && (w_src1Hit || w_src2Hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stalls, flushes and interrupt entry sequencing for
// a Fetch/Decode/Execute pipeline, plus a saturating stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  de_mem_read,
    input  logic [REG_ADDR_W-1:0] de_write_add,
    input  logic [REG_ADDR_W-1:0] fd_src1,
    input  logic [REG_ADDR_W-1:0] fd_src2,
    input  logic [1:0]            fd_src_valid,
    input  logic                  branch_taken,
    input  logic                  int_req,
    input  logic                  mem_busy,
    output logic                  pc_en,
    output logic                  fd_en,
    output logic                  fd_flush,
    output logic                  de_en,
    output logic                  de_flush,
    output logic [1:0]            int_push,
    output logic                  int_ack,
    output logic [2:0]            state,
    output logic [15:0]           stall_count
);

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_stallCount;
    logic        w_hazard;

    hazard_detect u_hazard_detect (
        .i_de_mem_read (de_mem_read),
        .i_de_write_add(de_write_add),
        .i_fd_src1     (fd_src1),
        .i_fd_src2     (fd_src2),
        .i_fd_src_valid(fd_src_valid),
        .o_hazard      (w_hazard)
    );

    // State register; reset abandons any interrupt sequence in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and pipeline controls; reset overrides to a flushed, frozen pipe
    always_comb begin
        w_nextState = r_state;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        de_en       = 1'b1;
        fd_flush    = 1'b0;
        de_flush    = 1'b0;
        int_push    = PUSH_NONE;
        int_ack     = 1'b0;

        if (!rst_n) begin
            w_nextState = ST_RUN;
            pc_en       = 1'b0;
            fd_en       = 1'b0;
            de_en       = 1'b0;
            fd_flush    = 1'b1;
            de_flush    = 1'b1;
        end else if (mem_busy) begin
            // Memory not ready freezes everything; interrupt states hold in place
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            if (r_state == ST_RUN) begin
                w_nextState = ST_MEM_WAIT;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (int_req) begin
                        pc_en       = 1'b0;
                        fd_flush    = 1'b1;
                        w_nextState = ST_INT_PC;
                    end else if (w_hazard) begin
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_en       = 1'b0;
                    fd_en       = 1'b0;
                    de_en       = 1'b0;
                    w_nextState = ST_RUN;
                end
                ST_INT_PC: begin
                    pc_en       = 1'b0;
                    fd_en       = 1'b0;
                    de_flush    = 1'b1;
                    int_push    = PUSH_PC;
                    w_nextState = ST_INT_FLAGS;
                end
                ST_INT_FLAGS: begin
                    pc_en       = 1'b0;
                    fd_en       = 1'b0;
                    de_flush    = 1'b1;
                    int_push    = PUSH_FLAGS;
                    w_nextState = ST_INT_JUMP;
                end
                ST_INT_JUMP: begin
                    fd_flush    = 1'b1;
                    int_ack     = 1'b1;
                    w_nextState = ST_RUN;
                end
                default: begin
                    w_nextState = ST_RUN;
                end
            endcase
        end
    end

    // Count every cycle the PC is held, sticking at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= 16'd0;
        end else if (!pc_en && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign state       = r_state;
    assign stall_count = r_stallCount;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        de_mem_read;
    logic [2:0]  de_write_add;
    logic [2:0]  fd_src1;
    logic [2:0]  fd_src2;
    logic [1:0]  fd_src_valid;
    logic        branch_taken;
    logic        int_req;
    logic        mem_busy;
    logic        pc_en;
    logic        fd_en;
    logic        fd_flush;
    logic        de_en;
    logic        de_flush;
    logic [1:0]  int_push;
    logic        int_ack;
    logic [2:0]  state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    bit compareOn = 0;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de_mem_read (de_mem_read),
        .de_write_add(de_write_add),
        .fd_src1     (fd_src1),
        .fd_src2     (fd_src2),
        .fd_src_valid(fd_src_valid),
        .branch_taken(branch_taken),
        .int_req     (int_req),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .fd_flush    (fd_flush),
        .de_en       (de_en),
        .de_flush    (de_flush),
        .int_push    (int_push),
        .int_ack     (int_ack),
        .state       (state),
        .stall_count (stall_count)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: where the controller is in terms of "waiting on
    // memory" and "which step of the interrupt entry", plus the stall tally.
    bit mMemWait;
    int mIntStep;
    int mCount;

    typedef struct packed {
        logic       pcEn;
        logic       fdEn;
        logic       fdFlush;
        logic       deEn;
        logic       deFlush;
        logic [1:0] push;
        logic       ack;
    } exp_t;

    function automatic int expState();
        if (mMemWait) return 1;
        if (mIntStep != 0) return mIntStep + 1;
        return 0;
    endfunction

    function automatic exp_t expected();
        exp_t e;
        bit hazard;
        e = '{pcEn: 1, fdEn: 1, fdFlush: 0, deEn: 1, deFlush: 0, push: 2'b00, ack: 0};
        hazard = de_mem_read &&
                 ((fd_src_valid[0] && fd_src1 == de_write_add) ||
                  (fd_src_valid[1] && fd_src2 == de_write_add));
        if (!rst_n) begin
            e = '{pcEn: 0, fdEn: 0, fdFlush: 1, deEn: 0, deFlush: 1, push: 2'b00, ack: 0};
        end else if (mem_busy || mMemWait) begin
            e = '{pcEn: 0, fdEn: 0, fdFlush: 0, deEn: 0, deFlush: 0, push: 2'b00, ack: 0};
        end else if (mIntStep == 1 || mIntStep == 2) begin
            e = '{pcEn: 0, fdEn: 0, fdFlush: 0, deEn: 1, deFlush: 1,
                  push: (mIntStep == 1) ? 2'b01 : 2'b10, ack: 0};
        end else if (mIntStep == 3) begin
            e.fdFlush = 1;
            e.ack     = 1;
        end else if (branch_taken) begin
            e.fdFlush = 1;
            e.deFlush = 1;
        end else if (int_req) begin
            e.pcEn    = 0;
            e.fdFlush = 1;
        end else if (hazard) begin
            e.pcEn    = 0;
            e.fdEn    = 0;
            e.deFlush = 1;
        end
        return e;
    endfunction

    // Advance the model at each clock edge using the inputs of the ending cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMemWait = 0;
            mIntStep = 0;
            mCount   = 0;
        end else begin
            exp_t e;
            e = expected();
            if (!e.pcEn && mCount < 65535) mCount = mCount + 1;
            if (mIntStep != 0) begin
                if (!mem_busy) mIntStep = (mIntStep == 3) ? 0 : mIntStep + 1;
            end else if (mMemWait) begin
                if (!mem_busy) mMemWait = 0;
            end else if (mem_busy) begin
                mMemWait = 1;
            end else if (!branch_taken && int_req) begin
                mIntStep = 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int want);
        checks++;
        if (actual != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, want, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled away from the clock edge
    always @(negedge clk) begin
        if (compareOn) begin
            exp_t e;
            e = expected();
            checkOutput("pc_en", int'(pc_en), int'(e.pcEn));
            checkOutput("fd_en", int'(fd_en), int'(e.fdEn));
            checkOutput("fd_flush", int'(fd_flush), int'(e.fdFlush));
            checkOutput("de_en", int'(de_en), int'(e.deEn));
            checkOutput("de_flush", int'(de_flush), int'(e.deFlush));
            checkOutput("int_push", int'(int_push), int'(e.push));
            checkOutput("int_ack", int'(int_ack), int'(e.ack));
            checkOutput("state", int'(state), expState());
            checkOutput("stall_count", int'(stall_count), mCount);
        end
    end

    task automatic applyStimulus(input logic memRead, input logic [2:0] writeAdd,
                                 input logic [2:0] src1, input logic [2:0] src2,
                                 input logic [1:0] valid, input logic branch,
                                 input logic intReq, input logic memBusy);
        @(posedge clk);
        #2;
        de_mem_read  = memRead;
        de_write_add = writeAdd;
        fd_src1      = src1;
        fd_src2      = src2;
        fd_src_valid = valid;
        branch_taken = branch;
        int_req      = intReq;
        mem_busy     = memBusy;
    endtask

    task automatic idle();
        applyStimulus(0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        de_mem_read  = 1'b0;
        de_write_add = 3'd0;
        fd_src1      = 3'd0;
        fd_src2      = 3'd0;
        fd_src_valid = 2'b00;
        branch_taken = 1'b0;
        int_req      = 1'b0;
        mem_busy     = 1'b0;

        // Outputs while held in reset
        #7;
        checkOutput("rst state", int'(state), 0);
        checkOutput("rst pc_en", int'(pc_en), 0);
        checkOutput("rst fd_flush", int'(fd_flush), 1);
        checkOutput("rst de_flush", int'(de_flush), 1);
        checkOutput("rst stall_count", int'(stall_count), 0);

        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        compareOn = 1'b1;
        sample();
        checkOutput("first run pc_en", int'(pc_en), 1);
        checkOutput("first run state", int'(state), 0);

        // Load-use hazard on src1
        applyStimulus(1, 3'd3, 3'd3, 3'd0, 2'b01, 0, 0, 0);
        sample();
        checkOutput("hazard pc_en", int'(pc_en), 0);
        checkOutput("hazard de_flush", int'(de_flush), 1);
        checkOutput("hazard count before", int'(stall_count), 0);
        idle();
        sample();
        checkOutput("hazard count after", int'(stall_count), 1);

        // Same registers but sources unused: no stall
        applyStimulus(1, 3'd3, 3'd3, 3'd0, 2'b00, 0, 0, 0);
        sample();
        checkOutput("no-src pc_en", int'(pc_en), 1);
        idle();
        sample();
        checkOutput("no-src count", int'(stall_count), 1);

        // Branch wins over a concurrent hazard
        applyStimulus(1, 3'd5, 3'd0, 3'd5, 2'b10, 1, 0, 0);
        sample();
        checkOutput("branch fd_flush", int'(fd_flush), 1);
        checkOutput("branch de_flush", int'(de_flush), 1);
        checkOutput("branch pc_en", int'(pc_en), 1);
        idle();
        sample();
        checkOutput("branch count", int'(stall_count), 1);

        // Interrupt entry sequence
        applyStimulus(0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 1, 0);
        sample();
        checkOutput("int c1 state", int'(state), 0);
        checkOutput("int c1 fd_flush", int'(fd_flush), 1);
        idle();
        sample();
        checkOutput("int c2 state", int'(state), 2);
        checkOutput("int c2 push", int'(int_push), 1);
        idle();
        sample();
        checkOutput("int c3 state", int'(state), 3);
        checkOutput("int c3 push", int'(int_push), 2);
        idle();
        sample();
        checkOutput("int c4 state", int'(state), 4);
        checkOutput("int c4 ack", int'(int_ack), 1);
        idle();
        sample();
        checkOutput("int c5 state", int'(state), 0);
        checkOutput("int c5 ack", int'(int_ack), 0);
        checkOutput("int count", int'(stall_count), 4);

        // Memory busy while pushing flags freezes the sequence
        applyStimulus(0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 1, 0);
        idle();
        sample();
        checkOutput("intmem INT_PC", int'(state), 2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 0, 1);
            sample();
            checkOutput("intmem held state", int'(state), 3);
            checkOutput("intmem held push", int'(int_push), 0);
        end
        idle();
        sample();
        checkOutput("intmem resume state", int'(state), 3);
        checkOutput("intmem resume push", int'(int_push), 2);
        idle();
        sample();
        checkOutput("intmem ack", int'(int_ack), 1);
        idle();

        // Reset in the middle of the interrupt sequence
        applyStimulus(0, 3'd0, 3'd0, 3'd0, 2'b00, 0, 1, 0);
        idle();
        sample();
        checkOutput("intrst INT_PC", int'(state), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("intrst state", int'(state), 0);
        checkOutput("intrst count", int'(stall_count), 0);
        checkOutput("intrst pc_en", int'(pc_en), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            checkOutput("intrst no ack", int'(int_ack), 0);
            idle();
        end

        // Randomized traffic, occasionally pulsing reset mid-cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            rst_n        = 1'b1;
            de_mem_read  = ($urandom_range(0, 99) < 40);
            de_write_add = 3'($urandom_range(0, 3));
            fd_src1      = 3'($urandom_range(0, 3));
            fd_src2      = 3'($urandom_range(0, 3));
            fd_src_valid = 2'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 99) < 10);
            int_req      = ($urandom_range(0, 99) < 8);
            mem_busy     = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) == 0) begin
                @(negedge clk);
                #1;
                rst_n = 1'b0;
            end
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
